// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults and an alternate 800x600@60 set,
// with derived totals and a small helper for per-axis arithmetic.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t h;
    vga_axis_t v;
    bit        hs_pol;
    bit        vs_pol;
  } vga_mode_t;

  function automatic int unsigned axis_total(input vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock, negative syncs
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_HS_POL   = 1'b0;
  localparam bit          VGA640_VS_POL   = 1'b0;

  localparam vga_mode_t VGA_640X480 = '{
    h: '{VGA640_H_ACTIVE, VGA640_H_FP, VGA640_H_SYNC, VGA640_H_BP},
    v: '{VGA640_V_ACTIVE, VGA640_V_FP, VGA640_V_SYNC, VGA640_V_BP},
    hs_pol: VGA640_HS_POL,
    vs_pol: VGA640_VS_POL
  };

  localparam int unsigned VGA640_H_TOTAL = axis_total(VGA_640X480.h);
  localparam int unsigned VGA640_V_TOTAL = axis_total(VGA_640X480.v);

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int unsigned VGA800_H_ACTIVE = 800;
  localparam int unsigned VGA800_H_FP     = 40;
  localparam int unsigned VGA800_H_SYNC   = 128;
  localparam int unsigned VGA800_H_BP     = 88;
  localparam int unsigned VGA800_V_ACTIVE = 600;
  localparam int unsigned VGA800_V_FP     = 1;
  localparam int unsigned VGA800_V_SYNC   = 4;
  localparam int unsigned VGA800_V_BP     = 23;
  localparam bit          VGA800_HS_POL   = 1'b1;
  localparam bit          VGA800_VS_POL   = 1'b1;

  localparam vga_mode_t VGA_800X600 = '{
    h: '{VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP},
    v: '{VGA800_V_ACTIVE, VGA800_V_FP, VGA800_V_SYNC, VGA800_V_BP},
    hs_pol: VGA800_HS_POL,
    vs_pol: VGA800_VS_POL
  };

  localparam int unsigned VGA800_H_TOTAL = axis_total(VGA_800X600.h);
  localparam int unsigned VGA800_V_TOTAL = axis_total(VGA_800X600.v);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered sync output and
// next-position decode so the parent can register its outputs in step with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned FP     = VGA640_H_FP,
  parameter int unsigned SYNC   = VGA640_H_SYNC,
  parameter int unsigned BP     = VGA640_H_BP,
  parameter bit          POL    = 1'b0,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic [CW-1:0] cnt_nxt,
  output logic          wrap,
  output logic          sync,
  output logic          active_nxt
);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_param
    $fatal(1, "vga_axis_counter: every timing parameter must be non-zero");
  end

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt;

  assign wrap = ce && (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (ce) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign active_nxt = (cnt_nxt < ACT_END);

  // Reset parks at the last position so the first enabled edge lands on 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= LAST;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= (cnt_nxt >= SYNC_LO && cnt_nxt < SYNC_HI) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two chained axis counters with all outputs registered
// on the counter edge, plus one-cycle start-of-line / start-of-frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter bit          HS_POL   = VGA640_HS_POL,
  parameter bit          VS_POL   = VGA640_VS_POL,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           sol,
  output logic           sof
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_act_nxt;
  logic          v_act_nxt;
  logic          de_nxt;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h (
    .clk        (clk),
    .reset      (reset),
    .ce         (pix_ce),
    .cnt_nxt    (h_nxt),
    .wrap       (h_wrap),
    .sync       (hsync),
    .active_nxt (h_act_nxt)
  );

  // Vertical axis steps only on the edge where the horizontal axis wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v (
    .clk        (clk),
    .reset      (reset),
    .ce         (h_wrap),
    .cnt_nxt    (v_nxt),
    .wrap       (v_wrap),
    .sync       (vsync),
    .active_nxt (v_act_nxt)
  );

  assign de_nxt = h_act_nxt && v_act_nxt;

  // Outputs are built from next-count decode so they describe the same (h,v) as the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      de  <= 1'b0;
      px  <= '0;
      py  <= '0;
      sol <= 1'b0;
      sof <= 1'b0;
    end else begin
      de  <= de_nxt;
      px  <= de_nxt    ? X_W'(h_nxt) : '0;
      py  <= v_act_nxt ? Y_W'(v_nxt) : '0;
      sol <= h_wrap;
      sof <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing over the first lines,
// a reduced mode over a full frame with pix_ce toggling, and a tiny positive-sync mode.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Default 640x480 instance
  logic       d_reset, d_ce, d_hs, d_vs, d_de, d_sol, d_sof;
  logic [9:0] d_px, d_py;
  vga_timing_gen dut_d (
    .clk(clk), .reset(d_reset), .pix_ce(d_ce), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .px(d_px), .py(d_py), .sol(d_sol), .sof(d_sof)
  );

  // Reduced mode: H 40/4/8/4 (56), V 30/3/2/5 (40), 6-bit coordinates
  logic       m_reset, m_ce, m_hs, m_vs, m_de, m_sol, m_sof;
  logic [5:0] m_px, m_py;
  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .X_W(6), .Y_W(6)
  ) dut_m (
    .clk(clk), .reset(m_reset), .pix_ce(m_ce), .hsync(m_hs), .vsync(m_vs),
    .de(m_de), .px(m_px), .py(m_py), .sol(m_sol), .sof(m_sof)
  );

  // Tiny mode: H 4/1/2/1 (8), V 3/1/1/1 (6), positive syncs
  logic       s_reset, s_ce, s_hs, s_vs, s_de, s_sol, s_sof;
  logic [9:0] s_px, s_py;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset(s_reset), .pix_ce(s_ce), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .px(s_px), .py(s_py), .sol(s_sol), .sof(s_sof)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected {hsync, vsync, de, px[15:0], py[15:0]} for position (h,v) of a given mode
  function automatic logic [34:0] expv(input int h, input int v,
                                       input int ha, input int hf, input int hsw,
                                       input int va, input int vf, input int vsw,
                                       input bit hp, input bit vp);
    logic de_e;
    de_e = (h < ha) && (v < va);
    return {((h >= ha + hf) && (h < ha + hf + hsw)) ? hp : ~hp,
            ((v >= va + vf) && (v < va + vf + vsw)) ? vp : ~vp,
            de_e,
            de_e ? 16'(h) : 16'd0,
            (v < va) ? 16'(v) : 16'd0};
  endfunction

  int h, v, bad, cnt_de, cnt_sol, cnt_sof, cnt_a, cnt_b, frame_len;
  bit adv;

  initial begin
    d_reset = 1'b1; d_ce = 1'b1;
    m_reset = 1'b1; m_ce = 1'b1;
    s_reset = 1'b1; s_ce = 1'b1;
    tick; tick;

    // Reset values, with pix_ce high during reset
    check("d_reset_vals", {d_hs, d_vs, d_de, d_sol, d_sof, d_px, d_py}, {5'b11000, 20'd0});
    check("m_reset_vals", {m_hs, m_vs, m_de, m_sol, m_sof, m_px, m_py}, {5'b11000, 12'd0});
    check("s_reset_vals", {s_hs, s_vs, s_de, s_sol, s_sof, s_px, s_py}, {5'b00000, 20'd0});

    // ---------------- default mode: first two lines ----------------
    d_reset = 1'b0;
    tick;
    check("d_first_edge", {d_sof, d_sol, d_de, d_hs, d_vs, d_px, d_py}, {5'b11111, 20'd0});
    h = 0; v = 0; bad = 0; cnt_de = 1; cnt_sol = 1; cnt_a = 0;
    for (int i = 1; i < 1600; i++) begin
      tick;
      h++;
      if (h == 800) begin h = 0; v++; end
      if ({d_hs, d_vs, d_de, 16'(d_px), 16'(d_py)} !== expv(h, v, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0)) bad++;
      if ({d_sol, d_sof} !== {(h == 0), 1'b0}) bad++;
      cnt_de  += int'(d_de);
      cnt_sol += int'(d_sol);
      if (d_hs === 1'b0) cnt_a++;
    end
    check("d_model_2lines", bad, 0);
    check("d_de_2lines", cnt_de, 1280);
    check("d_sol_2lines", cnt_sol, 2);
    check("d_hsync_low_clks", cnt_a, 192);

    // Mid-line reset: advance to h=300 on line 2
    for (int i = 0; i < 301; i++) begin
      tick;
      h++;
      if (h == 800) begin h = 0; v++; end
    end
    check("d_pre_reset_pos", {d_de, d_px, d_py}, {1'b1, 10'd300, 10'd2});
    d_reset = 1'b1;
    tick;
    check("d_midline_reset", {d_hs, d_vs, d_de, d_sol, d_sof, d_px, d_py}, {5'b11000, 20'd0});
    d_reset = 1'b0; d_ce = 1'b0;
    tick;
    check("d_parked_hold", {d_hs, d_vs, d_de, d_sol, d_sof, d_px, d_py}, {5'b11000, 20'd0});
    d_ce = 1'b1;
    tick;
    check("d_restart_sof", {d_sof, d_sol, d_de, d_px, d_py}, {3'b111, 20'd0});
    d_ce = 1'b0;
    tick;
    check("d_strobe_clear_ce0", {d_sof, d_sol, d_de, d_px, d_py}, {3'b001, 20'd0});
    d_ce = 1'b1;
    tick; tick; tick;
    check("d_px3", {d_de, d_sol, d_px}, {2'b10, 10'd3});
    d_ce = 1'b0;
    tick; tick;
    check("d_hold_ce0", {d_hs, d_vs, d_de, d_px, d_py}, {3'b111, 10'd3, 10'd0});

    // ---------------- reduced mode: full frame, pix_ce toggling ----------------
    m_reset = 1'b0; m_ce = 1'b1;
    tick;
    check("m_first_edge", {m_sof, m_sol, m_de, m_px, m_py}, {3'b111, 12'd0});
    h = 0; v = 0; bad = 0; cnt_de = 1; cnt_sol = 1; cnt_sof = 1; cnt_a = 0; cnt_b = 0; frame_len = 0;
    for (int i = 1; i <= 4480; i++) begin
      m_ce = (i % 2 == 0);
      adv = m_ce;
      tick;
      if (adv) begin
        h++;
        if (h == 56) begin
          h = 0; v++;
          if (v == 40) v = 0;
        end
      end
      if ({m_hs, m_vs, m_de, 16'(m_px), 16'(m_py)} !== expv(h, v, 40, 4, 8, 30, 3, 2, 1'b0, 1'b0)) bad++;
      if ({m_sol, m_sof} !== {adv && h == 0, adv && h == 0 && v == 0}) bad++;
      if (m_sof === 1'b1 && frame_len == 0) frame_len = i;
      if (i < 4480) begin
        cnt_de  += int'(m_de);
        cnt_sol += int'(m_sol);
        cnt_sof += int'(m_sof);
        if (m_vs === 1'b0) cnt_a++;
        if (m_hs === 1'b0) cnt_b++;
      end
    end
    check("m_model_frame", bad, 0);
    check("m_frame_len", frame_len, 4480);
    check("m_de_count", cnt_de, 2400);
    check("m_sol_count", cnt_sol, 40);
    check("m_sof_count", cnt_sof, 1);
    check("m_vsync_low_clks", cnt_a, 224);
    check("m_hsync_low_clks", cnt_b, 640);

    // ---------------- tiny mode: positive syncs, joint wrap ----------------
    s_reset = 1'b0;
    tick;
    check("s_first_edge", {s_sof, s_sol, s_de, s_hs, s_vs}, 5'b11100);
    h = 0; v = 0; bad = 0; cnt_a = 0; cnt_b = 0; frame_len = 0;
    for (int i = 1; i <= 48; i++) begin
      tick;
      h++;
      if (h == 8) begin
        h = 0; v++;
        if (v == 6) v = 0;
      end
      if ({s_hs, s_vs, s_de, 16'(s_px), 16'(s_py)} !== expv(h, v, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1)) bad++;
      if ({s_sol, s_sof} !== {h == 0, h == 0 && v == 0}) bad++;
      if (s_sof === 1'b1 && frame_len == 0) frame_len = i;
      if (i < 48) begin
        cnt_a += int'(s_hs);
        cnt_b += int'(s_vs);
      end
    end
    check("s_model_frame", bad, 0);
    check("s_hsync_high_clks", cnt_a, 12);
    check("s_vsync_high_clks", cnt_b, 8);
    check("s_frame_len", frame_len, 48);
    check("s_wrap_sof", {s_sof, s_sol, s_de, s_px, s_py}, {3'b111, 20'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: hsync width
- H_BP 48: horizontal back porch
- V_ACTIVE 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vsync width
- V_BP 33: vertical back porch
- HS_POL 0: hsync asserted level
- VS_POL 0: vsync asserted level
- X_W 10: px width
- Y_W 10: py width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: system clock
- reset in 1: synchronous, active-high reset
- pix_ce in 1: pixel clock enable
- hsync out 1: horizontal sync
- vsync out 1: vertical sync
- de out 1: display enable (visible region)
- px out X_W: pixel column
- py out Y_W: pixel row
- sol out 1: start-of-line pulse
- sof out 1: start-of-frame pulse

Function
REQ-003 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 Horizontal counter h SHALL advance by 1 only on clk edges with pix_ce=1, wrapping H_TOTAL-1 -> 0.
REQ-005 Vertical counter v SHALL advance by 1 only on the edge where h wraps, wrapping V_TOTAL-1 -> 0 when h and v wrap together.
REQ-006 Horizontal region order SHALL be active [0,H_ACTIVE), front porch, sync, back porch; vertical order SHALL be the same.
REQ-007 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vsync SHALL follow the same rule using v, V_* and VS_POL.
REQ-008 de SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-009 px SHALL equal h when de=1, else 0; py SHALL equal v when v < V_ACTIVE, else 0.
REQ-010 All outputs SHALL be registered, updating on the same edge as the counters, so outputs always describe the current (h,v) with zero skew between outputs.
REQ-011 sol SHALL be 1 for exactly one clk cycle following each edge that moves h to 0.
REQ-012 sof SHALL be 1 for exactly one clk cycle following each edge that moves (h,v) to (0,0); sol SHALL be 1 in the same cycle.
REQ-013 sol and sof SHALL clear on the next clk edge regardless of pix_ce.
REQ-014 With pix_ce=0, h, v, hsync, vsync, de, px and py SHALL hold their values.
REQ-015 Arithmetic SHALL be unsigned and counter widths SHALL be derived via $clog2(H_TOTAL) and $clog2(V_TOTAL).
REQ-016 px and py SHALL be truncated or zero-extended to X_W and Y_W.
REQ-017 The block SHALL abort elaboration if any timing parameter is 0.

Reset
REQ-018 reset SHALL override pix_ce and load h=H_TOTAL-1 and v=V_TOTAL-1, so the first pix_ce edge after reset yields (0,0) with sof=1.
REQ-019 Reset output values SHALL be hsync=~HS_POL, vsync=~VS_POL, de=0, px=0, py=0, sol=0 and sof=0.
REQ-020 reset asserted mid-frame SHALL take effect on the next clk edge with no partial line or frame completion.

Structure
REQ-021 Package vga_timing_pkg SHALL hold the 640x480@60 default constants, derived totals and an alternate 800x600 constant set.
REQ-022 Sub-module vga_axis_counter (parameters ACTIVE, FP, SYNC, BP, POL) SHALL implement one axis (count enable, wrap flag, sync and active decode) and SHALL be instantiated twice.

Verification
REQ-023 Default parameters, pix_ce=1, after reset -> one frame lasts 420000 clks, hsync is low for h 656..751 (96 clks), and vsync is low for lines 490..491.
REQ-024 Default parameters, one full frame -> de count = 307200; sof count = 1; sol count = 525; px sequence 0..639 on each active line.
REQ-025 pix_ce toggled 1,0,1,0... -> frame lasts 840000 clks, outputs hold on pix_ce=0 cycles, and sof and sol are each exactly 1 clk wide.
REQ-026 reset asserted at h=300, v=200, then released -> the first pix_ce edge gives px=0, py=0, de=1 and sof=1.
REQ-027 Small parameters H=4/1/2/1, V=3/1/1/1, HS_POL=1, VS_POL=1 -> H_TOTAL=8, hsync=1 at h 5..6, vsync=1 at line 4, and the h and v wrap on the same edge produces sof.
